decode_hazard_ctrl: RTL

//  Parametrised decode-stage hazard controller for the pipelined core; replaces the fixed
//  two-stage RD/RegWrt flop chain and single-shot stall logic inside decode.

---
 rtl/decode_hazard_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/decode_hazard_ctrl.sv
// Decode-stage hazard controller: shift scoreboard of in-flight writes, stall/bubble
// generation and post-redirect flush window. Optional macro: DECODE_HAZARD_BYPASS_EN.
module decode_hazard_ctrl #(
  parameter int REG_AW    = 3,
  parameter int DEPTH     = 3,
  parameter int FLUSH_CYC = 2,
  parameter int CNT_W     = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       id_valid,
  input  logic [REG_AW-1:0]          id_rs,
  input  logic                       id_rs_used,
  input  logic [REG_AW-1:0]          id_rt,
  input  logic                       id_rt_used,
  input  logic [REG_AW-1:0]          id_rd,
  input  logic                       id_regwrt,
  input  logic                       ex_redirect,
  output logic                       stall,
  output logic                       bubble,
  output logic [REG_AW-1:0]          wb_rd,
  output logic                       wb_regwrt,
  output logic [$clog2(DEPTH+1)-1:0] inflight_cnt,
  output logic [CNT_W-1:0]           stall_cnt
);

  localparam int IW = $clog2(DEPTH+1);
  localparam int FW = (FLUSH_CYC > 1) ? $clog2(FLUSH_CYC) : 1;
`ifdef DECODE_HAZARD_BYPASS_EN
  // Regfile forwards same-cycle writes, so the oldest slot needs no compare.
  localparam int NCMP = DEPTH - 1;
`else
  localparam int NCMP = DEPTH;
`endif

  logic [DEPTH-1:0]             vld_pipe;
  logic [DEPTH-1:0]             v_nxt;
  logic [DEPTH-1:0][REG_AW-1:0] slot_rd;
  logic [DEPTH-1:0]             rs_hit, rt_hit;
  logic [FW-1:0]                flush_ctr;
  logic [IW-1:0]                cnt_nxt;
  logic                         haz, flush_act;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_cmp
      assign rs_hit[k] = (k < NCMP) && vld_pipe[k] && (slot_rd[k] == id_rs);
      assign rt_hit[k] = (k < NCMP) && vld_pipe[k] && (slot_rd[k] == id_rt);
    end
    // A redirect kills the wrong-path write as it moves from slot 0 to slot 1.
    for (k = 1; k < DEPTH; k++) begin : g_shift
      assign v_nxt[k] = vld_pipe[k-1] & ~((k == 1) & ex_redirect);
    end
  endgenerate

  assign haz       = id_valid & ((id_rs_used & (|rs_hit)) | (id_rt_used & (|rt_hit)));
  assign flush_act = ex_redirect | (flush_ctr != '0);
  assign stall     = haz & ~flush_act;
  assign bubble    = haz | flush_act;
  assign v_nxt[0]  = id_valid & id_regwrt & ~bubble;

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < DEPTH; i++) cnt_nxt = cnt_nxt + IW'(v_nxt[i]);
  end

  assign wb_rd     = slot_rd[DEPTH-1];
  assign wb_regwrt = vld_pipe[DEPTH-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_pipe     <= '0;
      slot_rd      <= '0;
      flush_ctr    <= '0;
      inflight_cnt <= '0;
      stall_cnt    <= '0;
    end else begin
      vld_pipe     <= v_nxt;
      inflight_cnt <= cnt_nxt;
      slot_rd[0]   <= id_rd;
      for (int i = 1; i < DEPTH; i++) slot_rd[i] <= slot_rd[i-1];
      if (ex_redirect)
        flush_ctr <= FW'(FLUSH_CYC - 1);
      else if (flush_ctr != '0)
        flush_ctr <= flush_ctr - 1'b1;
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule
